// File: rtl/ser_pattern_pkg.sv
// Shared types and default sizes for the serial pattern transmitter.
// Imported by the top block and the matcher.
package ser_pattern_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/ser_pattern_match.sv
// Pattern tracker for the transmitted stream.
// Produces the expected-found strobe and a saturating hit counter.
module ser_pattern_match
  import ser_pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             sbit,
  input  logic             bit_valid,
  input  logic             p_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             o_load,
  input  logic             overlap,
  output logic             found,
  output logic [CNT_W-1:0] hit_count
);

  localparam int SW = $clog2(PAT_W);
  localparam logic [SW-1:0] SMAX = SW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_reg;
  logic             ovl;
  logic [PAT_W-2:0] hist;
  logic [SW-1:0]    seen;
  logic [PAT_W-1:0] win;

  assign win   = {hist, sbit};
  assign found = bit_valid && (seen == SMAX) && (win == pat_reg);

  // Pattern/overlap config, history window and fill level.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pat_reg <= '0;
      ovl     <= 1'b0;
      hist    <= '0;
      seen    <= '0;
    end else begin
      if (o_load) ovl <= overlap;
      if (p_load) begin
        pat_reg <= pattern;
        hist    <= '0;
        seen    <= '0;
      end else if (bit_valid) begin
        hist <= win[PAT_W-2:0];
        if (found && !ovl) seen <= '0;
        else if (seen != SMAX) seen <= seen + SW'(1);
      end
    end
  end

  // Occurrence counter, sticks at all-ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) hit_count <= '0;
    else if (found && (hit_count != '1))
      hit_count <= hit_count + CNT_W'(1);
  end

endmodule

// File: rtl/ser_pattern_tx.sv
// Parallel-to-serial transmitter, MSB first, gapless back-to-back.
// Mirrors the detector's pattern config to drive expected hits.
module ser_pattern_tx
  import ser_pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic             p_load,
  input  logic             overlap,
  input  logic             o_load,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             exp_found,
  output logic [CNT_W-1:0] hit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  assign data_ready = (state == IDLE) || (cnt == '0);
  assign ser_valid  = (state == SHIFT);
  assign busy       = ser_valid;
  assign ser_out    = sreg[WIDTH-1];

  // Frame handshake and bit shifter; reloads on the last bit if offered.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_valid) begin
            sreg  <= data_in;
            cnt   <= LAST;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= sreg << 1;
            cnt  <= cnt - CW'(1);
          end else if (data_valid) begin
            sreg <= data_in;
            cnt  <= LAST;
          end else begin
            sreg  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ser_pattern_match #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) u_match (
    .clock    (clock),
    .rst_n    (rst_n),
    .sbit     (ser_out),
    .bit_valid(ser_valid),
    .p_load   (p_load),
    .pattern  (pattern),
    .o_load   (o_load),
    .overlap  (overlap),
    .found    (exp_found),
    .hit_count(hit_count)
  );

endmodule

// File: tb/tb_ser_pattern_tx.sv
// Randomized bench for ser_pattern_tx with a queue-based stream model.
// Directed scenarios pin the model with literal expectations.
module tb_ser_pattern_tx;

  localparam int WIDTH = 8;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_valid = 1'b0;
  logic             data_ready;
  logic [PAT_W-1:0] pattern = '0;
  logic             p_load = 1'b0;
  logic             overlap = 1'b0;
  logic             o_load = 1'b0;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             exp_found;
  logic [CNT_W-1:0] hit_count;

  int total = 0;
  int bad   = 0;

  ser_pattern_tx #(
    .WIDTH(WIDTH),
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .pattern   (pattern),
    .p_load    (p_load),
    .overlap   (overlap),
    .o_load    (o_load),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .exp_found (exp_found),
    .hit_count (hit_count)
  );

  always #5 clock = ~clock;

  // Model: bits still to send, recent bits since last clear, config.
  bit pend[$];
  bit hq[$];
  int mpat = 0;
  bit movl = 0;
  int mhit = 0;
  int acc_cnt = 0;

  // Logs of DUT behaviour on stream cycles.
  bit obits[$];
  bit ofound[$];
  bit ordy[$];

  function automatic bit m_valid();
    return pend.size() > 0;
  endfunction

  function automatic bit m_bit();
    return (pend.size() > 0) ? pend[0] : 1'b0;
  endfunction

  function automatic bit m_found();
    int v;
    if (!m_valid() || hq.size() != PAT_W - 1) return 1'b0;
    v = 0;
    foreach (hq[i]) v = v * 2 + int'(hq[i]);
    v = v * 2 + int'(m_bit());
    return v == mpat;
  endfunction

  always @(posedge clock or negedge rst_n) begin : model
    bit v, b, f, rdy;
    if (!rst_n) begin
      pend.delete();
      hq.delete();
      mpat = 0;
      movl = 0;
      mhit = 0;
    end else begin
      v   = m_valid();
      b   = m_bit();
      f   = m_found();
      rdy = pend.size() <= 1;
      if (f && mhit < (1 << CNT_W) - 1) mhit++;
      if (p_load) begin
        mpat = int'(pattern);
        hq.delete();
      end else if (v) begin
        if (f && !movl) hq.delete();
        else begin
          hq.push_back(b);
          if (hq.size() > PAT_W - 1) void'(hq.pop_front());
        end
      end
      if (o_load) movl = overlap;
      if (v) void'(pend.pop_front());
      if (data_valid && rdy) begin
        for (int i = WIDTH - 1; i >= 0; i--) pend.push_back(data_in[i]);
        acc_cnt++;
      end
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    chk("ser_valid", 32'(ser_valid), 32'(m_valid()));
    chk("busy", 32'(busy), 32'(m_valid()));
    chk("data_ready", 32'(data_ready), 32'(pend.size() <= 1));
    chk("exp_found", 32'(exp_found), 32'(m_found()));
    chk("hit_count", 32'(hit_count), 32'(mhit));
    if (m_valid()) chk("ser_out", 32'(ser_out), 32'(m_bit()));
    if (ser_valid === 1'b1) begin
      obits.push_back(ser_out);
      ofound.push_back(exp_found);
      ordy.push_back(data_ready);
    end
  end

  function automatic int bits_val();
    int v = 0;
    foreach (obits[i]) v = (v << 1) | int'(obits[i]);
    return v;
  endfunction

  function automatic int found_mask();
    int m = 0;
    foreach (ofound[i]) if (ofound[i]) m |= (1 << i);
    return m;
  endfunction

  function automatic int rdy_count();
    int c = 0;
    foreach (ordy[i]) c += int'(ordy[i]);
    return c;
  endfunction

  task automatic clr_log();
    obits.delete();
    ofound.delete();
    ordy.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg(logic [PAT_W-1:0] p, logic ov);
    p_load  = 1'b1;
    pattern = p;
    o_load  = 1'b1;
    overlap = ov;
    tick();
    p_load = 1'b0;
    o_load = 1'b0;
  endtask

  task automatic send(logic [WIDTH-1:0] v);
    int c0 = acc_cnt;
    int n = 0;
    data_valid = 1'b1;
    data_in    = v;
    do begin
      tick();
      n++;
    end while (acc_cnt == c0 && n < 40);
    data_valid = 1'b0;
    chk("accept", 32'(acc_cnt != c0), 32'd1);
  endtask

  initial begin
    // Reset held low, then idle after release.
    repeat (2) tick();
    chk("rst_valid", 32'(ser_valid), 32'd0);
    chk("rst_out", 32'(ser_out), 32'd0);
    chk("rst_found", 32'(exp_found), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_valid", 32'(ser_valid), 32'd0);

    // Overlap mode on 8'hB6.
    do_reset();
    cfg(4'b1011, 1'b1);
    clr_log();
    send(8'hB6);
    repeat (10) tick();
    chk("s2_len", 32'(obits.size()), 32'd8);
    chk("s2_bits", 32'(bits_val()), 32'hB6);
    chk("s2_mask", 32'(found_mask()), 32'h48);
    chk("s2_hits", 32'(hit_count), 32'd2);

    // Non-overlap mode on the same frame.
    do_reset();
    cfg(4'b1011, 1'b0);
    clr_log();
    send(8'hB6);
    repeat (10) tick();
    chk("s3_mask", 32'(found_mask()), 32'h08);
    chk("s3_hits", 32'(hit_count), 32'd1);

    // Back-to-back frames with a cross-boundary match.
    do_reset();
    cfg(4'b1011, 1'b1);
    clr_log();
    send(8'h01);
    send(8'h60);
    repeat (10) tick();
    chk("s4_len", 32'(obits.size()), 32'd16);
    chk("s4_bits", 32'(bits_val()), 32'h0160);
    chk("s4_rdy", 32'(rdy_count()), 32'd2);
    chk("s4_mask", 32'(found_mask()), 32'h400);
    chk("s4_hits", 32'(hit_count), 32'd1);

    // Idle gap keeps history.
    do_reset();
    cfg(4'b1011, 1'b1);
    clr_log();
    send(8'h01);
    repeat (11) tick();
    send(8'h60);
    repeat (10) tick();
    chk("s5_mask", 32'(found_mask()), 32'h400);
    chk("s5_hits", 32'(hit_count), 32'd1);

    // Pattern reload in the gap clears history.
    clr_log();
    send(8'h01);
    repeat (9) tick();
    p_load  = 1'b1;
    pattern = 4'b1011;
    tick();
    p_load = 1'b0;
    repeat (2) tick();
    send(8'h60);
    repeat (10) tick();
    chk("s5p_mask", 32'(found_mask()), 32'h0);
    chk("s5p_hits", 32'(hit_count), 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    cfg(4'b1011, 1'b1);
    send(8'hB6);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_valid", 32'(ser_valid), 32'd0);
    chk("s6_hits", 32'(hit_count), 32'd0);
    chk("s6_ready", 32'(data_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clr_log();
    send(8'h00);
    repeat (10) tick();
    chk("s6_mask", 32'(found_mask()), 32'h88);
    chk("s6_hits2", 32'(hit_count), 32'd2);

    // Hit counter saturation.
    do_reset();
    cfg(4'b0000, 1'b1);
    for (int k = 0; k < 36; k++) send(8'h00);
    repeat (10) tick();
    chk("sat_hits", 32'(hit_count), 32'hFF);

    // Randomized traffic with config changes at arbitrary times.
    do_reset();
    cfg(4'b1011, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      p_load     = ($urandom_range(0, 15) == 0);
      pattern    = PAT_W'($urandom_range(0, 15));
      o_load     = ($urandom_range(0, 7) == 0);
      overlap    = 1'($urandom_range(0, 1));
      data_in    = WIDTH'($urandom);
      data_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    p_load     = 1'b0;
    o_load     = 1'b0;
    data_valid = 1'b0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
